// File: rtl/com_serial_divider.sv
// rtl/com_serial_divider.sv - multi-cycle unsigned restoring divider (optional macro COM_DIV_HOLD_EN)
// With COM_DIV_HOLD_EN defined, a zero divisor leaves quotient/remainder unchanged.
module com_serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             rfd,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           nextState;
    logic [WIDTH-1:0] dReg;      // dividend shifts out of the top, quotient bits shift in at the bottom
    logic [WIDTH-1:0] vReg;
    logic [WIDTH-1:0] rReg;
    logic [CW-1:0]    iterCnt;
    logic             zeroDiv;

    logic [WIDTH:0]   rShift;
    logic [WIDTH-1:0] rDiff;
    logic             qBit;

    // The partial remainder is always below the divisor, so WIDTH bits hold it;
    // only the shifted value needs the extra top bit for the compare.
    always_comb begin
        rShift = {rReg, dReg[WIDTH-1]};
        qBit   = (rShift >= {1'b0, vReg});
        rDiff  = rShift[WIDTH-1:0] - vReg;
    end

    always_comb begin
        nextState = state;
        rfd       = 1'b0;
        case (state)
            IDLE: begin
                rfd = 1'b1;
                if (start) begin
                    nextState = BUSY;
                end
            end
            BUSY: begin
                if (iterCnt == LAST_ITER) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dReg        <= '0;
            vReg        <= '0;
            rReg        <= '0;
            iterCnt     <= '0;
            zeroDiv     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            valid       <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dReg    <= dividend;
                        vReg    <= divisor;
                        rReg    <= '0;
                        iterCnt <= '0;
                        zeroDiv <= (divisor == '0);
                    end
                end
                BUSY: begin
                    dReg    <= {dReg[WIDTH-2:0], qBit};
                    rReg    <= qBit ? rDiff : rShift[WIDTH-1:0];
                    iterCnt <= iterCnt + 1'b1;
                end
                DONE: begin
                    valid       <= 1'b1;
                    div_by_zero <= zeroDiv;
`ifdef COM_DIV_HOLD_EN
                    if (!zeroDiv) begin
                        quotient  <= dReg;
                        remainder <= rReg;
                    end
`else
                    // A zero divisor always subtracts, so the iterations naturally
                    // leave all-ones in the quotient and the dividend in the remainder.
                    quotient  <= dReg;
                    remainder <= rReg;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_com_serial_divider.sv
// tb/tb_com_serial_divider.sv - scoreboard testbench for com_serial_divider
module tb_com_serial_divider;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             rfd;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             valid;
    logic             div_by_zero;

    com_serial_divider #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .rfd(rfd),
        .quotient(quotient),
        .remainder(remainder),
        .valid(valid),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
        int               capEdge;
    } sb_t;

    sb_t              sbQ[$];
    int               checks = 0;
    int               failures = 0;
    int               edgeCount = 0;
    int               validCount = 0;
    int               acceptCount = 0;
    logic [WIDTH-1:0] lastQ = '0;
    logic [WIDTH-1:0] lastR = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) edgeCount <= edgeCount + 1;

    always @(negedge clk) begin
        #1;
        if (valid) begin
            validCount++;
            if (sbQ.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                sb_t e;
                e = sbQ.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", div_by_zero, e.dz);
                check("latency", edgeCount - e.capEdge, WIDTH + 1);
                if (e.b != 0) begin
                    check("identity", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
                    check("rem_lt_div", 64'(remainder < e.b), 64'd1);
                end
            end
        end
        if (reset) begin
            sbQ.delete();
            lastQ = '0;
            lastR = '0;
        end else if (start && rfd) begin
            sb_t e;
            e.a = dividend;
            e.b = divisor;
            e.dz = (divisor == 0);
            if (divisor == 0) begin
`ifndef COM_DIV_HOLD_EN
                lastQ = '1;
                lastR = dividend;
`endif
            end else begin
                lastQ = dividend / divisor;
                lastR = dividend % divisor;
            end
            e.q = lastQ;
            e.r = lastR;
            e.capEdge = edgeCount + 1;
            sbQ.push_back(e);
            acceptCount++;
        end
    end

    task automatic waitValid(input int target);
        int n = 0;
        while (validCount < target && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("wait_valid", 64'(validCount >= target), 64'd1);
    endtask

    task automatic request(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int target;
        target = validCount + 1;
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
        dividend = $urandom;
        divisor = $urandom;
        waitValid(target);
    endtask

    initial begin
        int vc0;
        int n;
        int target;

        repeat (3) @(negedge clk);
        #2;
        check("rst_rfd", rfd, 1);
        check("rst_valid", valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk);
        start = 1'b1;
        dividend = 1000;
        divisor = 10;
        vc0 = validCount;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("rfd_busy", rfd, 0);
        waitValid(vc0 + 1);

        request(7, 3);
        request(32'hFFFF_FFFF, 1);
        request(5, 9);

        request(1000, 10);
        request(5, 0);
        request(9, 4);

        // start held while busy must not queue a second operation
        @(negedge clk);
        start = 1'b1;
        dividend = 1000;
        divisor = 10;
        vc0 = validCount;
        @(negedge clk);
        dividend = 50;
        divisor = 7;
        repeat (10) @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("valid_seen", valid, 1);
        start = 1'b1;
        dividend = 50;
        divisor = 7;
        @(negedge clk);
        start = 1'b0;
        #2;
        check("single_pulse", validCount - vc0, 1);
        waitValid(vc0 + 2);

        // reset during iteration 16
        @(negedge clk);
        start = 1'b1;
        dividend = 1000;
        divisor = 10;
        vc0 = validCount;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("abort_quotient", quotient, 0);
        check("abort_rfd", rfd, 1);
        repeat (40) @(negedge clk);
        check("abort_no_valid", validCount - vc0, 0);
        request(9, 4);

        // back-to-back random operands
        target = acceptCount + 2000;
        n = 0;
        while (n < 80000) begin
            @(negedge clk);
            n++;
            if (acceptCount >= target) break;
            start = 1'b1;
            dividend = $urandom;
            divisor = $urandom >> $urandom_range(0, 31);
            if (divisor == 0) divisor = 1;
        end
        start = 1'b0;
        check("random_accepts", 64'(acceptCount >= target), 64'd1);
        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("drained", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/com_serial_divider.md
Name: com_serial_divider

Overview:
- Multi-cycle unsigned restoring divider that computes the centroid quotients x_sum/mass and y_sum/mass for the center-of-mass tracker.
- It is the responder side of the tracker's divider handshake: it accepts one dividend/divisor pair per frame and returns quotient and fractional remainder.
- Two instances are used, one per axis. They share the pixel clock.

Parameters:
- WIDTH, 32, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  pixel clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request strobe; operands captured when start && rfd at a rising edge.
- dividend  input  WIDTH  unsigned numerator (axis-weighted colour sum).
- divisor  input  WIDTH  unsigned denominator (total colour mass).
- rfd  output  1  ready-for-data; high only in IDLE.
- quotient  output  WIDTH  registered result; held until the next result.
- remainder  output  WIDTH  registered remainder; held until the next result.
- valid  output  1  one-cycle pulse when quotient/remainder update.
- div_by_zero  output  1  registered flag; set with the result of a zero-divisor operation, cleared with the next result.

Behaviour:
- Reset: state=IDLE, rfd=1, valid=0, quotient=0, remainder=0, div_by_zero=0.
- Reset mid-operation: aborts the division. No valid pulse. Outputs take their reset values on the next edge.
- States: IDLE, BUSY, DONE.
- IDLE:
  - rfd=1.
  - If start at edge E0: capture dividend into shift register D and divisor into register V; clear partial remainder R (WIDTH+1 bits) and iteration counter; go to BUSY.
  - start while rfd=0 is ignored. No queuing, no error.
- BUSY: one iteration per edge, edges E1..E_WIDTH.
  - R' = {R[WIDTH-1:0], D[MSB]}; shift D left.
  - If R' >= V: R = R' - V and shift 1 into the quotient LSB; else R = R' and shift 0.
  - After WIDTH iterations go to DONE.
- DONE (edge E_WIDTH+1):
  - Load quotient, remainder=R[WIDTH-1:0] and div_by_zero.
  - valid=1 for exactly this one cycle; return to IDLE.
  - rfd is high in the same cycle valid is high, so back-to-back requests are allowed.
- Latency: valid is high in the cycle following edge E0+WIDTH+1, i.e. WIDTH+1 edges after capture. Throughput is one result per WIDTH+2 cycles.
- Divisor zero:
  - Detected at capture; the same latency is kept so timing is deterministic.
  - Result per Optional Feature; div_by_zero=1.
- dividend < divisor: quotient=0, remainder=dividend.
- No wrap or overflow is possible: quotient <= dividend always.
- Operand inputs may change freely after capture without affecting the result.

Optional Feature:
- Macro COM_DIV_HOLD_EN.
- Defined: on zero divisor, quotient and remainder keep their previous values. valid and div_by_zero still assert. The tracker therefore keeps the last good centroid when the colour is absent from a frame.
- Undefined: on zero divisor, quotient is all ones and remainder=dividend.

Test Plan:
- WIDTH=32; start with dividend=1000, divisor=10 -> rfd low next cycle; valid exactly 33 edges after capture; quotient=100, remainder=0, div_by_zero=0.
- dividend=7, divisor=3 -> quotient=2, remainder=1. Then dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=5, divisor=9 -> quotient=0, remainder=5.
- Divide 5/0 immediately after 1000/10 -> macro undefined: quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. Macro defined: quotient=100, remainder=0, div_by_zero=1. Latency 33 edges in both cases.
- Assert start with 50/7 for 10 cycles after accepting 1000/10 -> only one valid pulse, result 100/0. Then start 50/7 on the valid cycle -> accepted; next result 7/1.
- Assert reset at iteration 16 of 1000/10 -> no valid pulse; quotient=0, rfd=1. A new request 9/4 afterwards gives 2/1.
- Random unsigned operand pairs (2000 runs, nonzero divisor) checked against a reference model -> quotient*divisor+remainder=dividend and remainder<divisor.
